// File: rtl/pc_round_seq_pkg.sv
// ascon_pack: shared types and constants for the ASCON constant-addition
// sequencer.
//   type_state     : 320-bit permutation state, five 64-bit lanes, lane 0 lowest.
//   type_pc_fsm    : sequencer states IDLE / RUN / DONE.
//   round_constant : per-round constant table, entry r = {4'hF - r, r}.
//   rc_lookup      : guarded table read; indices past the last round give 0.
package ascon_pack;

    localparam int ROUND_MAX = 12;
    localparam int ROUND_W   = 4;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_pc_fsm;

    localparam logic [7:0] round_constant [0:ROUND_MAX-1] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    function automatic logic [7:0] rc_lookup(input logic [ROUND_W-1:0] r);
        logic [7:0] rc;
        if (r <= 4'd11) begin
            rc = round_constant[r];
        end else begin
            rc = 8'h00;
        end
        return rc;
    endfunction

endpackage

// File: rtl/pc_round_seq_pc.sv
// pc_round_seq_pc: combinational ASCON constant addition.
// XORs the constant of round_i into the low byte of lane CONST_LANE;
// every other state bit passes through.
//   state_i  in   type_state  state before constant addition
//   round_i  in   4           round index 0..11
//   state_o  out  type_state  state after constant addition
module pc_round_seq_pc
    import ascon_pack::*;
#(
    parameter int CONST_LANE = 2
) (
    input  type_state              state_i,
    input  logic [ROUND_W-1:0]     round_i,
    output type_state              state_o
);

    // Constant addition on the selected lane only.
    always_comb begin
        state_o = state_i;
        state_o[CONST_LANE][7:0] = state_i[CONST_LANE][7:0] ^ rc_lookup(round_i);
    end

endmodule

// File: rtl/pc_round_seq.sv
// pc_round_seq: sequential constant-addition engine for the ASCON permutation.
// Loads a 320-bit state, applies one round constant per clock for rounds
// 12-N .. 11 (N = ROUNDS_A for mode 0, ROUNDS_B for mode 1) and presents the
// result under a valid/ready handshake.
//   clock_i   in   1           clock, rising edge
//   resetb_i  in   1           asynchronous active-low reset
//   start_i   in   1           load state_i and start a permutation
//   mode_i    in   1           0 = p^a, 1 = p^b (sampled with an accepted start)
//   state_i   in   type_state  input state
//   ready_i   in   1           downstream takes state_o while valid_o = 1
//   busy_o    out  1           high in RUN and DONE
//   valid_o   out  1           state_o holds the final result
//   round_o   out  4           round being applied (0 in IDLE, 11 in DONE)
//   state_o   out  type_state  working state register
module pc_round_seq
    import ascon_pack::*;
#(
    parameter int ROUNDS_A   = 12,
    parameter int ROUNDS_B   = 6,
    parameter int CONST_LANE = 2
) (
    input  logic                   clock_i,
    input  logic                   resetb_i,
    input  logic                   start_i,
    input  logic                   mode_i,
    input  type_state              state_i,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [ROUND_W-1:0]     round_o,
    output type_state              state_o
);

    if ((ROUNDS_A < 1) || (ROUNDS_A > ROUND_MAX) ||
        (ROUNDS_B < 1) || (ROUNDS_B > ROUND_MAX) ||
        (CONST_LANE < 0) || (CONST_LANE > 4)) begin : g_param_err
        $error("pc_round_seq: ROUNDS_A/ROUNDS_B must be 1..12 and CONST_LANE 0..4");
    end

    localparam logic [ROUND_W-1:0] COUNT_A = 4'(ROUNDS_A);
    localparam logic [ROUND_W-1:0] COUNT_B = 4'(ROUNDS_B);
    localparam logic [ROUND_W-1:0] FIRST_A = 4'(ROUND_MAX - ROUNDS_A);
    localparam logic [ROUND_W-1:0] FIRST_B = 4'(ROUND_MAX - ROUNDS_B);

    type_pc_fsm           fsm_r;
    type_state            state_r;
    logic [ROUND_W-1:0]   round_r;
    logic [ROUND_W-1:0]   remaining_r;
    logic                 busy_r;
    logic                 valid_r;

    type_state            pc_state_s;
    logic [ROUND_W-1:0]   load_round_s;
    logic [ROUND_W-1:0]   load_count_s;

    pc_round_seq_pc #(
        .CONST_LANE (CONST_LANE)
    ) u_pc (
        .state_i (state_r),
        .round_i (round_r),
        .state_o (pc_state_s)
    );

    // First round index and round count for a start in the requested mode.
    always_comb begin
        if (mode_i) begin
            load_round_s = FIRST_B;
            load_count_s = COUNT_B;
        end else begin
            load_round_s = FIRST_A;
            load_count_s = COUNT_A;
        end
    end

    // Sequencer: load on start, one constant per RUN cycle, hold result in DONE.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_r       <= IDLE;
            state_r     <= '0;
            round_r     <= 4'd0;
            remaining_r <= 4'd0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (start_i) begin
                        fsm_r       <= RUN;
                        state_r     <= state_i;
                        round_r     <= load_round_s;
                        remaining_r <= load_count_s;
                        busy_r      <= 1'b1;
                    end else begin
                        round_r     <= 4'd0;
                    end
                end
                RUN: begin
                    state_r <= pc_state_s;
                    if (remaining_r == 4'd1) begin
                        // Last round: round_r stays at 11 instead of wrapping.
                        fsm_r       <= DONE;
                        valid_r     <= 1'b1;
                        remaining_r <= 4'd0;
                    end else begin
                        round_r     <= round_r + 4'd1;
                        remaining_r <= remaining_r - 4'd1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        if (start_i) begin
                            // Back-to-back load: busy stays high.
                            fsm_r       <= RUN;
                            state_r     <= state_i;
                            round_r     <= load_round_s;
                            remaining_r <= load_count_s;
                        end else begin
                            fsm_r   <= IDLE;
                            round_r <= 4'd0;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    fsm_r       <= IDLE;
                    round_r     <= 4'd0;
                    remaining_r <= 4'd0;
                    busy_r      <= 1'b0;
                    valid_r     <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_r;
    assign valid_o = valid_r;
    assign round_o = round_r;
    assign state_o = state_r;

endmodule

// File: tb/tb_pc_round_seq.sv
// Self-checking bench for pc_round_seq. Two instances share the stimulus:
// inst 0 uses ROUNDS_B=6, inst 1 uses ROUNDS_B=8; sel picks which one gets
// start and whose outputs are observed. Expected results come from the
// round-constant formula {15-r, r} folded over rounds 12-N..11.
module tb_pc_round_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic         ready;
    logic         sel;
    logic [319:0] st_in;

    logic         start0_s, start1_s;
    logic         busy0_s, valid0_s, busy1_s, valid1_s;
    logic [3:0]   round0_s, round1_s;
    logic [319:0] out0_s, out1_s;

    logic         o_busy, o_valid;
    logic [3:0]   o_round;
    logic [319:0] o_state;

    int checks;
    int failures;

    assign start0_s = start & ~sel;
    assign start1_s = start & sel;
    assign o_busy   = sel ? busy1_s  : busy0_s;
    assign o_valid  = sel ? valid1_s : valid0_s;
    assign o_round  = sel ? round1_s : round0_s;
    assign o_state  = sel ? out1_s   : out0_s;

    pc_round_seq #(.ROUNDS_A(12), .ROUNDS_B(6), .CONST_LANE(2)) dut0 (
        .clock_i (clk), .resetb_i (rst_n), .start_i (start0_s), .mode_i (mode),
        .state_i (st_in), .ready_i (ready), .busy_o (busy0_s), .valid_o (valid0_s),
        .round_o (round0_s), .state_o (out0_s)
    );

    pc_round_seq #(.ROUNDS_A(12), .ROUNDS_B(8), .CONST_LANE(2)) dut1 (
        .clock_i (clk), .resetb_i (rst_n), .start_i (start1_s), .mode_i (mode),
        .state_i (st_in), .ready_i (ready), .busy_o (busy1_s), .valid_o (valid1_s),
        .round_o (round1_s), .state_o (out1_s)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] rnd320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int nrounds(input logic s, input logic m);
        if (!m) return 12;
        return s ? 8 : 6;
    endfunction

    // Reference result: XOR of constants for rounds 12-n..11 into lane 2 low byte.
    function automatic logic [319:0] model(input logic [319:0] st, input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int r = 12 - n; r < 12; r++) x = x ^ 8'(((15 - r) << 4) | r);
        st[2*64 +: 8] = st[2*64 +: 8] ^ x;
        return st;
    endfunction

    task automatic start_op(input logic m, input logic [319:0] st);
        start = 1'b1;
        mode  = m;
        st_in = st;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        st_in = rnd320();
    endtask

    // Called just after the accepting edge; walks RUN and checks the DONE result.
    task automatic run_phase(input logic m, input logic [319:0] st, output logic [319:0] exp);
        int n;
        n   = nrounds(sel, m);
        exp = model(st, n);
        for (int k = 0; k < n; k++) begin
            check_val("run_busy",  320'(o_busy),  320'd1);
            check_val("run_valid", 320'(o_valid), 320'd0);
            check_val("run_round", 320'(o_round), 320'(12 - n + k));
            start = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        check_val("done_valid", 320'(o_valid), 320'd1);
        check_val("done_busy",  320'(o_busy),  320'd1);
        check_val("done_round", 320'(o_round), 320'd11);
        check_val("done_state", o_state, exp);
    endtask

    task automatic hold_done(input int cyc, input logic [319:0] exp);
        ready = 1'b0;
        for (int k = 0; k < cyc; k++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("hold_valid", 320'(o_valid), 320'd1);
            check_val("hold_state", o_state, exp);
        end
        start = 1'b0;
    endtask

    task automatic release_idle();
        ready = 1'b1;
        start = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        check_val("idle_valid", 320'(o_valid), 320'd0);
        check_val("idle_busy",  320'(o_busy),  320'd0);
        check_val("idle_round", 320'(o_round), 320'd0);
    endtask

    task automatic b2b_start(input logic m, input logic [319:0] st);
        ready = 1'b1;
        start = 1'b1;
        mode  = m;
        st_in = st;
        @(negedge clk);
        ready = 1'b0;
        start = 1'b0;
        st_in = rnd320();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [319:0] st, st2, exp;
        logic         m, m2;
        checks   = 0;
        failures = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        ready = 1'b0;
        sel   = 1'b0;
        st_in = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy",  320'(o_busy),  320'd0);
        check_val("rst_valid", 320'(o_valid), 320'd0);
        check_val("rst_round", 320'(o_round), 320'd0);
        check_val("rst_state", o_state, 320'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // p^a on an all-zero state: all twelve constants cancel.
        start_op(1'b0, 320'd0);
        run_phase(1'b0, 320'd0, exp);
        check_val("pa_zero", o_state, 320'd0);
        release_idle();

        // p^b with six rounds on zero: lane 2 becomes 0x11.
        start_op(1'b1, 320'd0);
        run_phase(1'b1, 320'd0, exp);
        check_val("pb6_lane2", 320'(o_state[191:128]), 320'h11);
        release_idle();

        // p^b with eight rounds: all-ones lane 2 unchanged, other lanes pass through.
        sel = 1'b1;
        st  = rnd320();
        st[191:128] = 64'hFFFF_FFFF_FFFF_FFFF;
        start_op(1'b1, st);
        run_phase(1'b1, st, exp);
        check_val("pb8_state", o_state, st);
        hold_done(5, exp);
        release_idle();
        sel = 1'b0;

        // Back-to-back: new start accepted in DONE on the ready edge.
        st = rnd320();
        start_op(1'b1, st);
        run_phase(1'b1, st, exp);
        st2 = rnd320();
        b2b_start(1'b0, st2);
        run_phase(1'b0, st2, exp);
        release_idle();

        // Asynchronous reset in the middle of RUN.
        start_op(1'b0, rnd320());
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy",  320'(o_busy),  320'd0);
        check_val("arst_valid", 320'(o_valid), 320'd0);
        check_val("arst_state", o_state, 320'd0);
        check_val("arst_round", 320'(o_round), 320'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized permutations on either instance.
        for (int t = 0; t < 20; t++) begin
            sel = 1'($urandom_range(0, 1));
            m   = 1'($urandom_range(0, 1));
            st  = rnd320();
            start_op(m, st);
            run_phase(m, st, exp);
            hold_done($urandom_range(0, 3), exp);
            if ($urandom_range(0, 1) == 1) begin
                m2  = 1'($urandom_range(0, 1));
                st2 = rnd320();
                b2b_start(m2, st2);
                run_phase(m2, st2, exp);
            end
            release_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
